// File: rtl/tcm_arb_pkg.sv
// Shared widths and helpers for the TCM data-port arbiter.
package tcm_arb_pkg;

    localparam int unsigned TAG_W  = 11;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tcm_dport_arb_if.sv
// Requester-side and memory-side signals of the TCM data-port arbiter.
interface tcm_dport_arb_if #(
    parameter int unsigned NREQ = 2
);
    import tcm_arb_pkg::*;

    logic [NREQ*ADDR_W-1:0] req_addr_i;
    logic [NREQ*DATA_W-1:0] req_data_wr_i;
    logic [NREQ-1:0]        req_rd_i;
    logic [NREQ*STRB_W-1:0] req_wr_i;
    logic [NREQ*TAG_W-1:0]  req_tag_i;
    logic [NREQ-1:0]        req_accept_o;
    logic [NREQ-1:0]        rsp_ack_o;
    logic [DATA_W-1:0]      rsp_data_o;
    logic                   rsp_error_o;
    logic [TAG_W-1:0]       rsp_tag_o;

    logic [ADDR_W-1:0]      m_addr_o;
    logic [DATA_W-1:0]      m_data_wr_o;
    logic                   m_rd_o;
    logic [STRB_W-1:0]      m_wr_o;
    logic [TAG_W-1:0]       m_tag_o;
    logic                   m_accept_i;
    logic                   m_ack_i;
    logic [DATA_W-1:0]      m_data_rd_i;
    logic                   m_error_i;
    logic [TAG_W-1:0]       m_resp_tag_i;

    logic                   proto_err_o;

    modport slave (
        input  req_addr_i, req_data_wr_i, req_rd_i, req_wr_i, req_tag_i,
        output req_accept_o, rsp_ack_o, rsp_data_o, rsp_error_o, rsp_tag_o,
        output m_addr_o, m_data_wr_o, m_rd_o, m_wr_o, m_tag_o,
        input  m_accept_i, m_ack_i, m_data_rd_i, m_error_i, m_resp_tag_i,
        output proto_err_o
    );

    modport master (
        output req_addr_i, req_data_wr_i, req_rd_i, req_wr_i, req_tag_i,
        input  req_accept_o, rsp_ack_o, rsp_data_o, rsp_error_o, rsp_tag_o,
        input  m_addr_o, m_data_wr_o, m_rd_o, m_wr_o, m_tag_o,
        output m_accept_i, m_ack_i, m_data_rd_i, m_error_i, m_resp_tag_i,
        input  proto_err_o
    );

endinterface

// File: rtl/tcm_arb_owner_fifo.sv
// In-order record of which requester owns each outstanding TCM transaction.
module tcm_arb_owner_fifo
    import tcm_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o   = (count_q == CntW'(DEPTH));
        empty_o  = (count_q == '0);
        count_o  = count_q;
        head_o   = mem_q[rd_ptr_q];
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        // Depth is a power of two, so pointers wrap by natural overflow.
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/tcm_dport_arb.sv
// Round-robin arbiter sharing the tcm_mem data port; routes in-order responses to their owners.
module tcm_dport_arb
    import tcm_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic           clk,
    input  logic           rst,
    tcm_dport_arb_if.slave bus
);
    localparam int unsigned OwnW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int unsigned CntW = clog2(OUTSTANDING) + 1;

    logic [OwnW-1:0] rr_ptr_q, rr_ptr_d;
    logic            proto_err_q, proto_err_d;
    logic [NREQ-1:0] pending;
    logic [OwnW-1:0] win, sel, head;
    logic            found, grant_valid, issue, pop;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        pending = '0;
        found   = 1'b0;
        win     = '0;
        for (int r = 0; r < NREQ; r++) begin
            pending[r] = bus.req_rd_i[r] | (|bus.req_wr_i[r*STRB_W +: STRB_W]);
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && pending[(int'(rr_ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = OwnW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    // Full is the pre-pop value, keeping the issue path free of the ack.
    always_comb begin
        sel         = rst ? win : '0;
        grant_valid = rst & found & ~fifo_full;
        issue       = grant_valid & bus.m_accept_i;
        pop         = rst & bus.m_ack_i & ~fifo_empty;
        rr_ptr_d    = rr_ptr_q;
        if (issue) rr_ptr_d = OwnW'((int'(win) + 1) % NREQ);
        proto_err_d = proto_err_q | (bus.m_ack_i & fifo_empty);
    end

    always_comb begin
        bus.m_addr_o     = bus.req_addr_i[int'(sel)*ADDR_W +: ADDR_W];
        bus.m_data_wr_o  = bus.req_data_wr_i[int'(sel)*DATA_W +: DATA_W];
        bus.m_tag_o      = bus.req_tag_i[int'(sel)*TAG_W +: TAG_W];
        bus.m_rd_o       = grant_valid & bus.req_rd_i[sel];
        bus.m_wr_o       = grant_valid ? bus.req_wr_i[int'(sel)*STRB_W +: STRB_W] : '0;
        bus.req_accept_o = issue ? (NREQ'(1) << sel) : '0;
        bus.rsp_ack_o    = pop ? (NREQ'(1) << head) : '0;
        bus.rsp_data_o   = bus.m_data_rd_i;
        bus.rsp_error_o  = bus.m_error_i;
        bus.rsp_tag_o    = bus.m_resp_tag_i;
        bus.proto_err_o  = proto_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    tcm_arb_owner_fifo #(
        .WIDTH (OwnW),
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .data_i  (win),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= CntW'(OUTSTANDING));

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Self-checking bench: grant/route vector table, directed corner sequences, random traffic vs model.
module tb_tcm_dport_arb;
    import tcm_arb_pkg::*;

    localparam int NREQ  = 2;
    localparam int OUTST = 4;

    logic clk, rst;
    tcm_dport_arb_if #(.NREQ(NREQ)) bus ();

    tcm_dport_arb #(.NREQ(NREQ), .OUTSTANDING(OUTST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Requester state
    logic [31:0] r_addr [NREQ];
    logic [31:0] r_data [NREQ];
    logic        r_rd   [NREQ];
    logic [3:0]  r_wr   [NREQ];
    logic [10:0] r_tag  [NREQ];
    logic [10:0] tag_ctr;

    // Reference model: outstanding transactions in issue order, TCM contents
    typedef struct {
        int          owner;
        logic [10:0] tag;
        logic [31:0] rdata;
        bit          is_rd;
    } txn_t;
    txn_t        outq [$];
    logic [31:0] mem [logic [29:0]];
    int          rr_m;
    bit          proto_m;
    int          ack_mode;   // 0 never, 1 whenever outstanding, 2 random
    bit          spur, acc_en, acc_rand;
    int          issues [NREQ];
    int          total, last_win;
    logic [31:0] last_rsp_data [NREQ];
    bit          got_rsp [NREQ];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return ~a;
    endfunction

    function automatic logic err_of(input logic [10:0] t);
        return t[0] ^ t[3];
    endfunction

    task automatic drive_reqs();
        for (int r = 0; r < NREQ; r++) begin
            bus.req_addr_i[r*32 +: 32]    = r_addr[r];
            bus.req_data_wr_i[r*32 +: 32] = r_data[r];
            bus.req_rd_i[r]               = r_rd[r];
            bus.req_wr_i[r*4 +: 4]        = r_wr[r];
            bus.req_tag_i[r*11 +: 11]     = r_tag[r];
        end
    endtask

    task automatic new_req(input int r, input bit rd, input logic [3:0] wr,
                           input logic [31:0] addr, input logic [31:0] data);
        r_rd[r]   = rd;
        r_wr[r]   = wr;
        r_addr[r] = addr;
        r_data[r] = data;
        r_tag[r]  = tag_ctr;
        tag_ctr   = tag_ctr + 11'd1;
    endtask

    task automatic refill_cont();
        for (int r = 0; r < NREQ; r++)
            if (!r_rd[r] && r_wr[r] == 4'h0)
                new_req(r, 1'b1, 4'h0, 32'h8000_0000 + ($urandom_range(0, 15) << 2), $urandom);
    endtask

    task automatic refill_rand();
        for (int r = 0; r < NREQ; r++)
            if (!r_rd[r] && r_wr[r] == 4'h0 && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1)
                    new_req(r, 1'b1, 4'h0, 32'h8000_0000 + ($urandom_range(0, 15) << 2), $urandom);
                else
                    new_req(r, 1'b0, 4'($urandom_range(1, 15)),
                            32'h8000_0000 + ($urandom_range(0, 15) << 2), $urandom);
            end
    endtask

    task automatic clear_reqs();
        for (int r = 0; r < NREQ; r++) begin
            r_rd[r] = 1'b0;
            r_wr[r] = 4'h0;
        end
    endtask

    // One clock: drive, predict from the model, compare, advance the model.
    task automatic cycle();
        bit          ack, acc, full, pop, iss;
        int          win, rr;
        logic [1:0]  exp_acc, exp_rsp;
        logic        exp_rd;
        logic [3:0]  exp_wr;
        logic [31:0] cur;
        txn_t        t;
        drive_reqs();
        acc = acc_rand ? ($urandom_range(0, 3) != 0) : acc_en;
        if (spur) ack = 1'b1;
        else if (ack_mode == 1) ack = (outq.size() > 0);
        else if (ack_mode == 2) ack = (outq.size() > 0) && ($urandom_range(0, 2) != 0);
        else ack = 1'b0;
        bus.m_accept_i = acc;
        bus.m_ack_i    = ack;
        if (outq.size() > 0) begin
            bus.m_data_rd_i  = outq[0].rdata;
            bus.m_resp_tag_i = outq[0].tag;
            bus.m_error_i    = err_of(outq[0].tag);
        end else begin
            bus.m_data_rd_i  = $urandom;
            bus.m_resp_tag_i = 11'h0;
            bus.m_error_i    = 1'b0;
        end
        #2;
        full = (outq.size() >= OUTST);
        win  = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr = (rr_m + k) % NREQ;
            if (r_rd[rr] || r_wr[rr] != 4'h0) win = rr;
        end
        iss     = (win >= 0) && !full && acc;
        exp_acc = iss ? 2'(1 << win) : 2'b00;
        exp_rd  = (win >= 0 && !full) ? r_rd[win] : 1'b0;
        exp_wr  = (win >= 0 && !full) ? r_wr[win] : 4'h0;
        pop     = ack && (outq.size() > 0);
        exp_rsp = pop ? 2'(1 << outq[0].owner) : 2'b00;
        chk("req_accept", 32'(bus.req_accept_o), 32'(exp_acc));
        chk("m_rd", 32'(bus.m_rd_o), 32'(exp_rd));
        chk("m_wr", 32'(bus.m_wr_o), 32'(exp_wr));
        chk("rsp_ack", 32'(bus.rsp_ack_o), 32'(exp_rsp));
        chk("proto_err", 32'(bus.proto_err_o), 32'(proto_m));
        if (win >= 0) begin
            chk("m_addr", bus.m_addr_o, r_addr[win]);
            chk("m_tag", 32'(bus.m_tag_o), 32'(r_tag[win]));
            chk("m_data_wr", bus.m_data_wr_o, r_data[win]);
        end
        if (pop) begin
            chk("rsp_tag", 32'(bus.rsp_tag_o), 32'(outq[0].tag));
            chk("rsp_error", 32'(bus.rsp_error_o), 32'(err_of(outq[0].tag)));
            if (outq[0].is_rd) chk("rsp_data", bus.rsp_data_o, outq[0].rdata);
            last_rsp_data[outq[0].owner] = bus.rsp_data_o;
            got_rsp[outq[0].owner]       = 1'b1;
        end
        if (ack && outq.size() == 0) proto_m = 1'b1;
        if (pop) void'(outq.pop_front());
        if (iss) begin
            t.owner = win;
            t.tag   = r_tag[win];
            t.is_rd = r_rd[win];
            t.rdata = mem_read(r_addr[win]);
            if (r_wr[win] != 4'h0) begin
                cur = t.rdata;
                for (int b = 0; b < 4; b++)
                    if (r_wr[win][b]) cur[8*b +: 8] = r_data[win][8*b +: 8];
                mem[r_addr[win][31:2]] = cur;
            end
            outq.push_back(t);
            rr_m         = (win + 1) % NREQ;
            issues[win]++;
            total++;
            last_win     = win;
            r_rd[win]    = 1'b0;
            r_wr[win]    = 4'h0;
        end
        @(posedge clk);
        #1;
    endtask

    // Reset with requests pending and memory handshakes high: everything must stay quiet.
    task automatic do_reset();
        new_req(0, 1'b1, 4'h0, 32'h1234_5670, 32'h0);
        new_req(1, 1'b0, 4'hF, 32'h7654_3210, 32'h0);
        drive_reqs();
        rst            = 1'b0;
        bus.m_accept_i = 1'b1;
        bus.m_ack_i    = 1'b1;
        #2;
        chk("rst_m_rd", 32'(bus.m_rd_o), 32'h0);
        chk("rst_m_wr", 32'(bus.m_wr_o), 32'h0);
        chk("rst_accept", 32'(bus.req_accept_o), 32'h0);
        chk("rst_rsp_ack", 32'(bus.rsp_ack_o), 32'h0);
        chk("rst_m_addr", bus.m_addr_o, 32'h1234_5670);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_proto", 32'(bus.proto_err_o), 32'h0);
        clear_reqs();
        outq.delete();
        rr_m    = 0;
        proto_m = 1'b0;
        spur    = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            issues[r]  = 0;
            got_rsp[r] = 1'b0;
        end
        total = 0;
    endtask

    typedef struct {
        logic [1:0] rd;
        logic [3:0] wr0, wr1;
        logic       acc, ack;
        logic [1:0] exp_acc;
        logic       exp_rd;
        logic [3:0] exp_wr;
        logic [1:0] exp_rsp;
        int         exp_win;
    } vec_t;
    vec_t tbl [10];

    int prev_total, base, bad_alt, prev_win;

    initial begin
        n_chk = 0; n_err = 0; tag_ctr = 11'h100;
        ack_mode = 1; acc_en = 1'b1; acc_rand = 1'b0; spur = 1'b0; last_win = -1;
        bus.m_data_rd_i = '0; bus.m_resp_tag_i = '0; bus.m_error_i = 1'b0;
        do_reset();

        // Vector table from reset (rr=0, empty): grant mux, round-robin step, response demux.
        tbl[0] = '{2'b00, 4'h0, 4'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 2'b00, 0};
        tbl[1] = '{2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h0, 2'b00, 1};
        tbl[2] = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h0, 2'b00, 0};
        tbl[3] = '{2'b00, 4'h0, 4'hF, 1'b0, 1'b0, 2'b00, 1'b0, 4'hF, 2'b00, 1};
        tbl[4] = '{2'b01, 4'h0, 4'h3, 1'b1, 1'b0, 2'b01, 1'b1, 4'h0, 2'b00, 0};
        tbl[5] = '{2'b01, 4'h0, 4'h3, 1'b1, 1'b0, 2'b10, 1'b0, 4'h3, 2'b00, 1};
        tbl[6] = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1, 4'h0, 2'b00, 0};
        tbl[7] = '{2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 2'b01, 0};
        tbl[8] = '{2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0, 4'h0, 2'b10, 0};
        tbl[9] = '{2'b00, 4'h0, 4'h0, 1'b1, 1'b0, 2'b00, 1'b0, 4'h0, 2'b00, 0};
        r_addr[0] = 32'h0000_1000; r_addr[1] = 32'h0000_2000;
        r_tag[0]  = 11'h011;       r_tag[1]  = 11'h022;
        for (int i = 0; i < 10; i++) begin
            r_rd[0] = tbl[i].rd[0]; r_rd[1] = tbl[i].rd[1];
            r_wr[0] = tbl[i].wr0;   r_wr[1] = tbl[i].wr1;
            drive_reqs();
            bus.m_accept_i  = tbl[i].acc;
            bus.m_ack_i     = tbl[i].ack;
            bus.m_data_rd_i = 32'hC0DE_0000 + 32'(i);
            #2;
            chk($sformatf("tbl%0d_accept", i), 32'(bus.req_accept_o), 32'(tbl[i].exp_acc));
            chk($sformatf("tbl%0d_m_rd", i), 32'(bus.m_rd_o), 32'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_m_wr", i), 32'(bus.m_wr_o), 32'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_rsp_ack", i), 32'(bus.rsp_ack_o), 32'(tbl[i].exp_rsp));
            chk($sformatf("tbl%0d_m_addr", i), bus.m_addr_o, r_addr[tbl[i].exp_win]);
            chk($sformatf("tbl%0d_rsp_data", i), bus.rsp_data_o, 32'hC0DE_0000 + 32'(i));
            @(posedge clk);
            #1;
        end

        // 1: single read, zero-latency accept, response next cycle
        do_reset();
        new_req(0, 1'b1, 4'h0, 32'h8000_0000, 32'h0);
        cycle();
        chk("t1_issue_r0", 32'(issues[0]), 32'd1);
        cycle();
        chk("t1_rsp_r0", 32'(got_rsp[0]), 32'd1);
        chk("t1_rsp_data", last_rsp_data[0], 32'h7FFF_FFFF);

        // 2: both requesting continuously -> strict alternation, 4 each
        do_reset();
        bad_alt = 0; prev_win = -1;
        for (int i = 0; i < 8; i++) begin
            refill_cont();
            prev_total = total;
            cycle();
            if (total != prev_total) begin
                if (last_win == prev_win) bad_alt++;
                prev_win = last_win;
            end
        end
        chk("t2_r0_accepts", 32'(issues[0]), 32'd4);
        chk("t2_r1_accepts", 32'(issues[1]), 32'd4);
        chk("t2_alternation", 32'(bad_alt), 32'd0);

        // 3: no acks -> stall at 4; ack on a full FIFO does not issue; next cycle resumes
        do_reset();
        ack_mode = 0;
        for (int i = 0; i < 8; i++) begin refill_cont(); cycle(); end
        chk("t3_stall_at_4", 32'(total), 32'd4);
        ack_mode = 1;
        refill_cont(); cycle();
        chk("t3_full_ack_no_issue", 32'(total), 32'd4);
        refill_cont(); cycle();
        chk("t3_resume", 32'(total), 32'd5);

        // 4: r1 writes, r0 reads back
        do_reset();
        ack_mode = 1;
        new_req(1, 1'b0, 4'hF, 32'h8000_0100, 32'hDEAD_BEEF);
        cycle();
        new_req(0, 1'b1, 4'h0, 32'h8000_0100, 32'h0);
        cycle();
        cycle();
        chk("t4_rsp_r0", 32'(got_rsp[0]), 32'd1);
        chk("t4_rdata", last_rsp_data[0], 32'hDEAD_BEEF);

        // 5: hold count at 2 with push+pop each cycle across FIFO wrap
        do_reset();
        ack_mode = 0;
        for (int i = 0; i < 2; i++) begin refill_cont(); cycle(); end
        ack_mode = 1;
        base = total;
        for (int i = 0; i < 12; i++) begin refill_cont(); cycle(); end
        chk("t5_push_pop_issues", 32'(total - base), 32'd12);
        ack_mode = 0;
        base = total;
        for (int i = 0; i < 6; i++) begin refill_cont(); cycle(); end
        chk("t5_room_left", 32'(total - base), 32'd2);

        // 6: spurious ack -> sticky proto_err; reset clears it and rr_ptr
        do_reset();
        ack_mode = 0;
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        new_req(0, 1'b1, 4'h0, 32'h8000_0004, 32'h0);
        cycle();
        cycle();
        chk("t6_proto_sticky", 32'(bus.proto_err_o), 32'd1);
        do_reset();
        ack_mode = 1;
        refill_cont();
        cycle();
        chk("t6_rr_after_reset", 32'(last_win), 32'd0);

        // Random traffic against the model
        do_reset();
        ack_mode = 2; acc_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin refill_rand(); cycle(); end
        ack_mode = 1; acc_rand = 1'b0;
        clear_reqs();
        for (int i = 0; i < 6; i++) cycle();
        chk("rand_drained", 32'(outq.size()), 32'd0);
        chk("rand_no_proto", 32'(bus.proto_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
